// File: rtl/sync_reset_reg_pipe.sv
// Maskable register vector with a DEPTH-stage write pipeline, synchronous reset and soft clear.
// Optional per-lane even parity on q is enabled by defining SYNC_RESET_REG_PIPE_PARITY_EN.
module sync_reset_reg_pipe #(
  parameter int               WIDTH       = 32,
  parameter int               LANE        = 8,
  parameter int               DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic [WIDTH-1:0]        d_i,
  input  logic [WIDTH/LANE-1:0]   mask_i,
  input  logic                    clr_i,
`ifdef SYNC_RESET_REG_PIPE_PARITY_EN
  input  logic                    par_inj_i,
  output logic [WIDTH/LANE-1:0]   q_par_o,
`endif
  output logic [WIDTH-1:0]        q_o,
  output logic                    q_upd_o,
  output logic                    busy_o
);

  localparam int NL   = WIDTH / LANE;
  localparam int LAST = DEPTH - 1;

  logic                clear_s;
  logic [DEPTH-1:0]    vld_q;
  logic [DEPTH-1:0]    vld_d;
  logic [WIDTH-1:0]    dat_q [DEPTH];
  logic [NL-1:0]       msk_q [DEPTH];
  logic [WIDTH-1:0]    q_q;
  logic [WIDTH-1:0]    q_d;
  logic                q_upd_q;
  logic                q_upd_d;

  assign clear_s = rst_i | clr_i;

  // Valid chain: stage 0 takes a write only if at least one lane is enabled.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = en_i & (|mask_i);
    for (int s = 1; s < DEPTH; s++) begin
      vld_d[s] = vld_q[s-1];
    end
  end

  // Payload stages shift unconditionally; they are only consumed when their valid bit is set.
  always_ff @(posedge clk_i) begin
    dat_q[0] <= d_i;
    msk_q[0] <= mask_i;
    for (int s = 1; s < DEPTH; s++) begin
      dat_q[s] <= dat_q[s-1];
      msk_q[s] <= msk_q[s-1];
    end
  end

  // Commit: enabled lanes of the last stage replace q, other lanes hold.
  always_comb begin
    q_d     = q_q;
    q_upd_d = vld_q[LAST];
    for (int i = 0; i < NL; i++) begin
      if (vld_q[LAST] && msk_q[LAST][i]) begin
        q_d[i*LANE +: LANE] = dat_q[LAST][i*LANE +: LANE];
      end else begin
        q_d[i*LANE +: LANE] = q_q[i*LANE +: LANE];
      end
    end
  end

  // Architectural state; reset and clear win over any commit or new write.
  always_ff @(posedge clk_i) begin
    if (clear_s) begin
      vld_q   <= '0;
      q_q     <= RESET_VALUE;
      q_upd_q <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      q_q     <= q_d;
      q_upd_q <= q_upd_d;
    end
  end

  assign q_o     = q_q;
  assign q_upd_o = q_upd_q;
  assign busy_o  = |vld_q;

`ifdef SYNC_RESET_REG_PIPE_PARITY_EN
  function automatic logic [NL-1:0] lane_parity(input logic [WIDTH-1:0] v);
    logic [NL-1:0] p;
    p = '0;
    for (int i = 0; i < NL; i++) begin
      p[i] = ^v[i*LANE +: LANE];
    end
    return p;
  endfunction

  logic [NL-1:0] par_q;
  logic [NL-1:0] par_d;
  logic [NL-1:0] dat_par_s;

  assign dat_par_s = lane_parity(dat_q[LAST]);

  // Written lanes take the parity of the committing data (optionally corrupted); others hold.
  always_comb begin
    par_d = par_q;
    for (int i = 0; i < NL; i++) begin
      if (vld_q[LAST] && msk_q[LAST][i]) begin
        par_d[i] = dat_par_s[i] ^ par_inj_i;
      end else begin
        par_d[i] = par_q[i];
      end
    end
  end

  // Parity register updates on the same edge as q.
  always_ff @(posedge clk_i) begin
    if (clear_s) begin
      par_q <= lane_parity(RESET_VALUE);
    end else begin
      par_q <= par_d;
    end
  end

  assign q_par_o = par_q;
`endif

endmodule

// File: tb/tb_sync_reset_reg_pipe.sv
// Scoreboard bench for sync_reset_reg_pipe: a DEPTH=2 and a DEPTH=1 instance share stimulus.
module tb_sync_reset_reg_pipe;

  localparam int          WIDTH = 32;
  localparam int          LANE  = 8;
  localparam int          NL    = 4;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RV    = 32'hA5A5_0000;

  typedef struct {
    int          due;
    logic [31:0] val;
  } exp_t;

  logic        clk    = 1'b0;
  logic        rst_i  = 1'b1;
  logic        clr_i  = 1'b0;
  logic        en_i   = 1'b0;
  logic [31:0] d_i    = 32'h0;
  logic [3:0]  mask_i = 4'h0;
  logic [31:0] q0, q1;
  logic        upd0, upd1, busy0, busy1;
`ifdef SYNC_RESET_REG_PIPE_PARITY_EN
  logic        par_inj_i = 1'b0;
  logic [3:0]  par0, par1;
`endif

  exp_t        sb0[$];
  exp_t        sb1[$];
  logic [31:0] model_q = RV;
  logic [31:0] cur_q [2];
  int          cyc    = 0;
  int          clr_at = -1;
  int          n_chk  = 0;
  int          n_fail = 0;
  int          r;

  sync_reset_reg_pipe #(.WIDTH(WIDTH), .LANE(LANE), .DEPTH(DEPTH), .RESET_VALUE(RV)) u_dut0 (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .d_i(d_i), .mask_i(mask_i), .clr_i(clr_i),
`ifdef SYNC_RESET_REG_PIPE_PARITY_EN
    .par_inj_i(par_inj_i), .q_par_o(par0),
`endif
    .q_o(q0), .q_upd_o(upd0), .busy_o(busy0)
  );

  sync_reset_reg_pipe #(.WIDTH(WIDTH), .LANE(LANE), .DEPTH(1), .RESET_VALUE(RV)) u_dut1 (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .d_i(d_i), .mask_i(mask_i), .clr_i(clr_i),
`ifdef SYNC_RESET_REG_PIPE_PARITY_EN
    .par_inj_i(par_inj_i), .q_par_o(par1),
`endif
    .q_o(q1), .q_upd_o(upd1), .busy_o(busy1)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] apply(input logic [31:0] old, input logic [31:0] nv,
                                        input logic [3:0] m);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < NL; i++) begin
      if (m[i]) res[i*LANE +: LANE] = nv[i*LANE +: LANE];
    end
    return res;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_dut(input int k, input logic upd, input logic [31:0] qv, input logic bz);
    exp_t e;
    bit   have;
    int   left;
    e.due = -1;
    e.val = 32'h0;
    if (k == 0) begin
      have = (sb0.size() > 0);
      if (have) e = sb0[0];
    end else begin
      have = (sb1.size() > 0);
      if (have) e = sb1[0];
    end
    if (upd) begin
      if (!have) begin
        chk($sformatf("dut%0d_unexpected_q_upd", k), {31'h0, upd}, 32'h0);
      end else begin
        chk($sformatf("dut%0d_commit_cycle", k), cyc, e.due);
        if (k == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
        cur_q[k] = e.val;
      end
    end else if (have && e.due == cyc) begin
      chk($sformatf("dut%0d_missing_q_upd", k), {31'h0, upd}, 32'h1);
      if (k == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
      cur_q[k] = e.val;
    end
    left = (k == 0) ? sb0.size() : sb1.size();
    chk($sformatf("dut%0d_q", k), qv, cur_q[k]);
    chk($sformatf("dut%0d_busy", k), {31'h0, bz}, {31'h0, left > 0});
  endtask

`ifdef SYNC_RESET_REG_PIPE_PARITY_EN
  function automatic logic [3:0] par_of(input logic [31:0] v);
    logic [3:0] p;
    for (int i = 0; i < NL; i++) p[i] = ^v[i*LANE +: LANE];
    return p;
  endfunction
`endif

  // Monitor: runs just after every rising edge and consumes the scoreboards.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (cyc == clr_at) begin
      cur_q[0] = RV;
      cur_q[1] = RV;
    end
    check_dut(0, upd0, q0, busy0);
    check_dut(1, upd1, q1, busy1);
`ifdef SYNC_RESET_REG_PIPE_PARITY_EN
    chk("dut0_parity", {28'h0, par0}, {28'h0, par_of(q0)});
    chk("dut1_parity", {28'h0, par1}, {28'h0, par_of(q1)});
`endif
  end

  // Driver: applies one cycle of inputs on the falling edge and records what should commit.
  task automatic step(input logic rs, input logic c, input logic e, input logic [31:0] dv,
                      input logic [3:0] m);
    @(negedge clk);
    rst_i  = rs;
    clr_i  = c;
    en_i   = e;
    d_i    = dv;
    mask_i = m;
    if (rs || c) begin
      sb0.delete();
      sb1.delete();
      model_q = RV;
      clr_at  = cyc + 1;
    end else if (e && m != 4'h0) begin
      model_q = apply(model_q, dv, m);
      sb0.push_back('{cyc + 1 + DEPTH, model_q});
      sb1.push_back('{cyc + 2, model_q});
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0, 4'h0);
  endtask

  task automatic wr(input logic [31:0] dv, input logic [3:0] m);
    step(1'b0, 1'b0, 1'b1, dv, m);
  endtask

  initial begin
    cur_q[0] = RV;
    cur_q[1] = RV;
    step(1'b1, 1'b0, 1'b0, 32'h0, 4'h0);
    idle();
    chk("reset_q", q0, RV);
    chk("reset_q_upd", {31'h0, upd0}, 32'h0);
    chk("reset_busy", {31'h0, busy0}, 32'h0);

    // full write, latency DEPTH (and 1 for the DEPTH=1 instance)
    wr(32'h1122_3344, 4'b1111);
    idle();
    chk("full_busy_e0", {31'h0, busy0}, 32'h1);
    chk("full_q_e0", q0, RV);
    chk("d1_q_e0", q1, RV);
    idle();
    chk("full_busy_e1", {31'h0, busy0}, 32'h1);
    chk("full_upd_e1", {31'h0, upd0}, 32'h0);
    chk("d1_q_e1", q1, 32'h1122_3344);
    chk("d1_upd_e1", {31'h0, upd1}, 32'h1);
    idle();
    chk("full_q_e2", q0, 32'h1122_3344);
    chk("full_upd_e2", {31'h0, upd0}, 32'h1);
    chk("full_busy_e2", {31'h0, busy0}, 32'h0);
    idle();
    chk("full_upd_e3", {31'h0, upd0}, 32'h0);

    // partial write
    wr(32'hFFFF_FFFF, 4'b0101);
    idle(); idle(); idle();
    chk("partial_q", q0, 32'h11FF_33FF);

    // back-to-back overlapping writes
    wr(32'h0000_AAAA, 4'b0011);
    wr(32'h0000_BB00, 4'b0010);
    idle(); idle();
    chk("b2b_q_first", q0, 32'h11FF_AAAA);
    chk("b2b_upd_first", {31'h0, upd0}, 32'h1);
    idle();
    chk("b2b_q_second", q0, 32'h11FF_BBAA);
    chk("b2b_upd_second", {31'h0, upd0}, 32'h1);
    idle();
    chk("b2b_upd_after", {31'h0, upd0}, 32'h0);

    // clear while a write is in flight, with en also high
    wr(32'h1234_5678, 4'b1111);
    step(1'b0, 1'b1, 1'b1, 32'h9999_9999, 4'b1111);
    idle();
    chk("clr_q", q0, RV);
    chk("clr_busy", {31'h0, busy0}, 32'h0);
    chk("clr_d1_q", q1, RV);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("clr_no_upd", {31'h0, upd0}, 32'h0);
    end

    // mask of zero is dropped
    wr(32'hFFFF_FFFF, 4'b0000);
    idle();
    chk("mask0_busy", {31'h0, busy0}, 32'h0);
    idle(); idle();
    chk("mask0_q", q0, RV);
    chk("mask0_upd", {31'h0, upd0}, 32'h0);

    // write right after clear deasserts is accepted
    step(1'b0, 1'b1, 1'b0, 32'h0, 4'h0);
    wr(32'hDEAD_BEEF, 4'b1111);
    idle();
    idle();
    chk("d1_after_clr", q1, 32'hDEAD_BEEF);
    idle();
    chk("after_clr_q", q0, 32'hDEAD_BEEF);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 99);
      step(r < 2, (r >= 2 && r < 6), $urandom_range(0, 3) != 0, $urandom,
           4'($urandom_range(0, 15)));
    end

    for (int i = 0; i < 4; i++) idle();
    chk("scoreboard_drained", sb0.size() + sb1.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_reset_reg_pipe.md
Name: sync_reset_reg_pipe

Overview:
- Parametrised, synchronously reset register vector with per-lane write mask, a configurable-depth write pipeline and a soft clear.
- Writes enter at the input and commit to the architectural output `q` exactly DEPTH cycles later.
- Only the lanes selected by the write mask change on commit.
- Used wherever retimed control/status registers need a wide, maskable, reset-to-known-value store in the synchronous-reset clock domains.

Parameters:
- WIDTH, 32, data width in bits; must be a multiple of LANE.
- LANE, 8, mask granularity in bits; NL = WIDTH/LANE lanes.
- DEPTH, 2, number of write-pipeline stages; legal range 1..8.
- RESET_VALUE, 0 (WIDTH bits), value loaded into `q` on `rst` or `clr`.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  write request; sampled every cycle, no backpressure.
- d  in  WIDTH  write data.
- mask  in  NL  lane enables for the write; bit i covers d[i*LANE +: LANE].
- clr  in  1  synchronous soft clear, same effect as `rst`.
- q  out  WIDTH  architectural register value.
- q_upd  out  1  one-cycle pulse: `q` changed value source (a commit happened) this cycle.
- busy  out  1  at least one write is in flight in the pipeline.

Behaviour:
- Pipeline state per stage s (0..DEPTH-1): `vld[s]`, `dat[s]` (WIDTH bits), `msk[s]` (NL bits).
- Stage 0 load: each edge, `vld[0] <= en & (|mask)`, `dat[0] <= d`, `msk[0] <= mask`.
  - A write with mask == 0 is dropped: no stage valid, no q_upd.
- Advance: stages shift every cycle unconditionally: `stage[s] <= stage[s-1]` for s >= 1. There is no stall.
- Commit: when `vld[DEPTH-1]` is set, each lane i with `msk[DEPTH-1][i]` set takes `dat[DEPTH-1]` lane i at the edge. Lanes with the mask bit clear hold their value.
- Latency:
  - en sampled at edge E → q reflects the write after edge E+DEPTH.
  - q_upd is high in the cycle following edge E+DEPTH, for one cycle.
- Back-to-back writes:
  - Accepted every cycle.
  - Commit in order.
  - Overlapping lanes: the later write wins.
  - Disjoint lanes: both survive.
- q_upd: registered as `vld[DEPTH-1]`, i.e. it asserts together with the q change. It pulses even if the written data equals the old value.
- busy: combinational OR of all `vld[s]`.
- Reset and clear (`rst` or `clr`) at edge:
  - q <= RESET_VALUE.
  - All `vld` <= 0, so in-flight writes are discarded.
  - q_upd <= 0.
  - `dat`/`msk` need no reset.
- Simultaneous events:
  - `rst`/`clr` with `en` in the same cycle: clear wins and the write is discarded.
  - `en` in the cycle after clear deasserts is accepted normally.
- Reset values: q = RESET_VALUE, q_upd = 0, busy = 0.
- DEPTH = 1: the single stage is both load and commit stage; latency 1 cycle of pipeline, commit at E+1.
- No X-propagation from uninitialised `dat` while `vld` = 0: commit logic gates on `vld`.

Optional Feature:
- Macro: SYNC_RESET_REG_PIPE_PARITY_EN.
- When defined:
  - Adds output port `q_par`, NL bits: even parity of each lane of `q`.
  - Parity is computed from the committing data and registered alongside `q`, so it is updated in the same edge.
  - Reset/clear value is the parity of the RESET_VALUE lanes.
  - Adds input `par_inj`, 1 bit: when high at commit, every written lane's parity bit is inverted. This is for error-path testing.
- When undefined: neither port exists and there is no parity logic. All other behaviour is identical.

Test Plan (WIDTH=32, LANE=8, DEPTH=2, RESET_VALUE=32'hA5A5_0000 unless stated):
- rst for 2 cycles, then idle → q=32'hA5A5_0000, q_upd=0, busy=0.
- en=1, d=32'h1122_3344, mask=4'b1111 at edge 0 → busy=1 after edges 0-1; q=32'h1122_3344 and q_upd=1 after edge 2 only.
- Partial write: from q=32'h1122_3344, write d=32'hFFFF_FFFF, mask=4'b0101 → q=32'h11FF_33FF two cycles later.
- Back-to-back: write mask=4'b0011 d=32'h0000_AAAA, next cycle mask=4'b0010 d=32'h0000_BB00 → q[15:0] = 16'hAAAA, then 16'hBBAA. q_upd is high for two consecutive cycles.
- clr asserted one cycle after a write (write in flight) with en=1 → q=32'hA5A5_0000, busy=0 next cycle, no later commit, no q_upd.
- mask=0 with en=1 → busy stays 0, q unchanged, no q_upd. DEPTH=1 build: a full write commits after 1 edge.
